// File: rtl/uart_pkg.sv
// Shared UART arbitration definitions.
//   state_t            : frame-level arbiter states
//   TAG_BASE           : upper nibble of the source tag byte that prefixes each frame
//   DEFAULT_ABORT_BYTE : byte emitted when the watchdog cuts a stalled producer off
//   tag_byte()         : builds the tag byte for a requester id
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAG   = 2'd1,
    DATA  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic [7:0] TAG_BASE           = 8'hF0;
  localparam logic [7:0] DEFAULT_ABORT_BYTE = 8'hFF;

  function automatic logic [7:0] tag_byte(input logic [3:0] id);
    return TAG_BASE | {4'h0, id};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority pick.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index; the search runs upward from here and wraps
//   valid : at least one request is set
//   idx   : index of the first set request at or after ptr
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk offsets from farthest to nearest so the closest request to ptr is
  // the one left standing after the loop.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UART TX byte port between
// N_REQ byte-stream producers. Each granted frame is prefixed with a tag
// byte (F0 | id); a producer that goes quiet mid-frame for TIMEOUT cycles is
// cut off with ABORT_BYTE and the port is released.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_req_valid/data/last, o_req_ready : per-requester byte streams
//   o_wdata, o_wvalid, i_wready        : single-register UART TX byte port
//   o_busy      : a frame is in progress
//   o_grant     : id of the current or last granted requester
//   o_abort_cnt : saturating count of watchdog aborts
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         N_REQ      = 4,
  parameter int         TIMEOUT    = 1023,
  parameter logic [7:0] ABORT_BYTE = DEFAULT_ABORT_BYTE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [7:0]         o_wdata,
  output logic               o_wvalid,
  input  logic               i_wready,
  output logic               o_busy,
  output logic [3:0]         o_grant,
  output logic [7:0]         o_abort_cnt
);

  localparam int            IW       = $clog2(N_REQ);
  localparam int            WW       = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          wvalid_d;
  logic [7:0]    wdata_d;
  logic [7:0]    abort_cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          slot_free;
  logic          g_valid, g_last;
  logic [7:0]    g_data;
  logic [IW-1:0] next_id;

  rr_picker #(.N(N_REQ)) u_picker (
    .req   (i_req_valid),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The output register may reload when empty or when it drains this cycle.
  assign slot_free = !o_wvalid || i_wready;
  assign g_valid   = i_req_valid[grant_q];
  assign g_last    = i_req_last[grant_q];
  assign g_data    = i_req_data[8*grant_q +: 8];
  assign next_id   = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

  assign o_busy  = (state_q != IDLE);
  assign o_grant = 4'(grant_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    wd_d        = wd_q;
    wvalid_d    = o_wvalid && !i_wready;
    wdata_d     = o_wdata;
    abort_cnt_d = o_abort_cnt;
    o_req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = TAG;
        end
      end

      TAG: begin
        if (slot_free) begin
          wvalid_d = 1'b1;
          wdata_d  = tag_byte(4'(grant_q));
          wd_d     = '0;
          state_d  = DATA;
        end
      end

      DATA: begin
        // Ready depends only on registered state and i_wready, never on valid.
        o_req_ready[grant_q] = slot_free;
        if (slot_free && g_valid) begin
          wvalid_d = 1'b1;
          wdata_d  = g_data;
          wd_d     = '0;
          if (g_last) begin
            rr_ptr_d = next_id;
            state_d  = IDLE;
          end
        end else if (wd_q == WD_LIMIT) begin
          state_d = ABORT;
        end else if (!g_valid) begin
          // Only producer silence counts; UART backpressure leaves it alone.
          wd_d = wd_q + 1'b1;
        end
      end

      ABORT: begin
        if (slot_free) begin
          wvalid_d    = 1'b1;
          wdata_d     = ABORT_BYTE;
          abort_cnt_d = (o_abort_cnt == 8'hFF) ? o_abort_cnt : o_abort_cnt + 8'd1;
          rr_ptr_d    = next_id;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      wd_q        <= '0;
      o_wvalid    <= 1'b0;
      o_wdata     <= 8'h00;
      o_abort_cnt <= 8'h00;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_q        <= wd_d;
      o_wvalid    <= wvalid_d;
      o_wdata     <= wdata_d;
      o_abort_cnt <= abort_cnt_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-level round-robin arbiter that shares the single UART TX byte port between up to N_REQ byte-stream producers, such as debug dumps, link status and heartbeat. It sits between the producers and the UART TX port, in place of a direct producer-to-UART connection.
- Each granted frame is prefixed with a source tag byte.
- A stalled producer is cut off by a watchdog that emits an abort byte and releases the port.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..16.
- TIMEOUT, 1023: maximum idle cycles mid-frame before abort, ≥ 1.
- ABORT_BYTE, 8'hFF: byte emitted on watchdog abort.

Ports:
- i_clk  in  1  system clock; one clock domain only.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  N_REQ  per-requester byte valid.
- i_req_data  in  8*N_REQ  per-requester byte; slice k is requester k.
- i_req_last  in  N_REQ  marks the final byte of the frame.
- o_req_ready  out  N_REQ  per-requester byte accepted this cycle.
- o_wdata  out  8  byte to UART TX.
- o_wvalid  out  1  o_wdata valid.
- i_wready  in  1  UART TX can accept a byte.
- o_busy  out  1  a frame is in progress (state ≠ IDLE).
- o_grant  out  4  id of the current or last granted requester.
- o_abort_cnt  out  8  saturating count of watchdog aborts.

## Operation
- UART side:
  - Single output register {o_wvalid, o_wdata}.
  - A byte is transferred when o_wvalid && i_wready.
  - The register may load when it is empty or is being drained in the same cycle, called "slot free".
- FSM states:
  - IDLE:
    - If any i_req_valid is set, pick the first set bit searching upward from rr_ptr, with wrap-around.
    - Set grant = k, then go to TAG.
  - TAG:
    - When the slot is free, load 8'hF0 | k and go to DATA.
  - DATA:
    - o_req_ready[grant] = slot free. All other ready bits are 0.
    - On valid && ready, load the byte.
    - If last is also set, set rr_ptr = (grant+1) mod N_REQ and go to IDLE.
  - ABORT:
    - When the slot is free, load ABORT_BYTE, increment o_abort_cnt (saturates at 255), set rr_ptr = grant+1 and go to IDLE.
- Watchdog:
  - Counter cleared on every accepted data byte and on entry to DATA.
  - Increments each DATA cycle in which i_req_valid[grant] = 0.
  - When it reaches TIMEOUT, go to ABORT.
  - A stalled i_wready does not count, because the producer is not at fault.
- The granted requester deasserting valid mid-frame is not an error until the timeout fires.
- Requests from non-granted sources are ignored (ready = 0) until the current frame ends.
- Reset:
  - state IDLE, o_wvalid 0, o_wdata 0, o_req_ready 0, o_busy 0, o_grant 0, rr_ptr 0, o_abort_cnt 0, watchdog 0.
  - Reset mid-frame discards the pending output byte and any partial frame.

## Timing
- IDLE → TAG costs 1 cycle. The tag appears on o_wvalid at the earliest 2 cycles after i_req_valid rises from IDLE.
- o_req_ready is combinational from state, grant, o_wvalid and i_wready. It has no combinational path from i_req_valid.
- With i_wready held at 1, data throughput is 1 byte/cycle. Frame overhead is the tag plus one IDLE cycle.
- Last byte accepted at cycle t: state is IDLE at t+1, and a new grant is possible at t+1 (TAG at t+2).
- Abort fires in the cycle the counter equals TIMEOUT. The ABORT byte loads at the first subsequent slot-free cycle.

## Structure
- Shared package (uart_pkg):
  - state enum {IDLE, TAG, DATA, ABORT}.
  - TAG_BASE = 8'hF0.
  - Default ABORT_BYTE.
- Sub-module rr_picker: combinational N_REQ-wide round-robin priority pick, with inputs req and ptr and outputs valid and idx. It is reusable for an Ethernet-side arbiter.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide.

## Test plan
- Single frame: req0 sends 3 bytes 11,22,33 (last on 33) with i_wready = 1 → UART sees F0,11,22,33; o_busy drops the cycle after 33 is accepted.
- Round-robin: req1 and req2 each hold a 1-byte frame (AA and BB) pending from reset → order is F1,AA,F2,BB. Then req1 again with req2 pending → F2 is not served before F1 twice; fairness holds.
- Backpressure: i_wready toggles 1,0,0,1 during req3's 4-byte frame → no byte is lost or duplicated, o_req_ready[3] = 0 while the slot is full, and the watchdog does not fire.
- Timeout: TIMEOUT = 8; req0 sends 1 byte without last, then drops valid → FF is emitted after 8 idle cycles, o_abort_cnt = 1, and req1's pending frame is served next.
- Reset mid-frame: assert i_rst while the DATA byte 55 is in the slot → outputs return to reset values immediately (asynchronously); after release, a fresh frame from req2 starts with F2.
- Saturation: force 300 aborts → o_abort_cnt holds 255.
